// File: rtl/cpu_pkg.sv
// Shared CPU front-end widths and the fetch queue entry layout.
package cpu_pkg;

   localparam int unsigned PC_W    = 11;
   localparam int unsigned INSTR_W = 32;

   // One fetched word together with the address it came from
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_queue.sv
// Instruction fetch queue between instruction memory and decode.
// A circular buffer with a skid reserve, so that fetches already in flight
// when fifo_full rises still find a free entry. A flush (taken branch)
// empties the queue in one edge and discards any wrong-path word.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SKID  = 1
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_valid,
   input  logic [INSTR_W-1:0]     wr_instr,
   input  logic [PC_W-1:0]        wr_pc,
   input  logic                   flush,
   input  logic                   rd_ready,
   output logic                   rd_valid,
   output logic [INSTR_W-1:0]     rd_instr,
   output logic [PC_W-1:0]        rd_pc,
   output logic                   fifo_full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t      r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_overflow;

   logic              w_rd_valid;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   fetch_entry_t      w_head;

   // Handshake decode; a full queue still accepts a write when the head leaves
   always_comb begin
      w_rd_valid = (r_count != '0);
      w_pop      = w_rd_valid & rd_ready & ~flush;
      w_push     = wr_valid & ~flush & ((r_count < CW'(DEPTH)) | w_pop);
      w_drop     = wr_valid & ~flush & ~w_push;
      w_head     = r_mem[r_rd_ptr];
   end

   // Entry storage; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_mem[r_wr_ptr] <= '{instr: wr_instr, pc: wr_pc};
      end
   end

   // Pointers, occupancy and the sticky overflow flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign rd_valid  = w_rd_valid;
   assign rd_instr  = w_head.instr;
   assign rd_pc     = w_head.pc;
   assign fifo_full = (r_count >= CW'(DEPTH - SKID));
   assign count     = r_count;
   assign overflow  = r_overflow;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=8, SKID=1).
module tb_fetch_queue;
   import cpu_pkg::*;

   logic               clk;
   logic               reset;
   logic               wr_valid;
   logic [INSTR_W-1:0] wr_instr;
   logic [PC_W-1:0]    wr_pc;
   logic               flush;
   logic               rd_ready;
   logic               rd_valid;
   logic [INSTR_W-1:0] rd_instr;
   logic [PC_W-1:0]    rd_pc;
   logic               fifo_full;
   logic [3:0]         count;
   logic               overflow;

   int n_checks = 0;
   int n_errors = 0;

   fetch_queue #(.DEPTH(8), .SKID(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_valid  (wr_valid),
      .wr_instr  (wr_instr),
      .wr_pc     (wr_pc),
      .flush     (flush),
      .rd_ready  (rd_ready),
      .rd_valid  (rd_valid),
      .rd_instr  (rd_instr),
      .rd_pc     (rd_pc),
      .fifo_full (fifo_full),
      .count     (count),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      flush    = 1'b0;
      reset    = 1'b0;
   endtask

   function automatic logic [31:0] instr_of(input int pc);
      return 32'hA500_0000 + 32'(pc);
   endfunction

   task automatic push_word(input int pc);
      wr_valid = 1'b1;
      wr_pc    = PC_W'(pc);
      wr_instr = instr_of(pc);
      step();
      wr_valid = 1'b0;
   endtask

   initial begin
      int rd_seen;
      int wr_idx;
      int cyc;

      idle();
      wr_instr = '0;
      wr_pc    = '0;
      reset    = 1'b1;
      wr_valid = 1'b1;
      step();
      step();
      idle();
      check("rst_count", 32'(count), 0);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_fifo_full", 32'(fifo_full), 0);
      check("rst_overflow", 32'(overflow), 0);

      // Fill with pc 0..7, no reads
      for (int i = 0; i < 8; i++) begin
         push_word(i);
         check($sformatf("fill_count_%0d", i), 32'(count), 32'(i + 1));
         check($sformatf("fill_full_%0d", i), 32'(fifo_full), (i + 1 >= 7) ? 1 : 0);
      end
      check("fill_overflow", 32'(overflow), 0);
      check("fill_rd_pc", 32'(rd_pc), 0);
      check("fill_rd_instr", rd_instr, instr_of(0));

      // Full queue: simultaneous write and read
      rd_ready = 1'b1;
      push_word(8);
      rd_ready = 1'b0;
      check("full_rw_count", 32'(count), 8);
      check("full_rw_rd_pc", 32'(rd_pc), 1);
      check("full_rw_overflow", 32'(overflow), 0);

      // Full queue: write with no read is dropped
      push_word(9);
      check("drop_count", 32'(count), 8);
      check("drop_overflow", 32'(overflow), 1);

      // Drain: expect 1..8, word 9 absent
      for (int k = 1; k <= 8; k++) begin
         check($sformatf("drain_pc_%0d", k), 32'(rd_pc), 32'(k));
         check($sformatf("drain_instr_%0d", k), rd_instr, instr_of(k));
         rd_ready = 1'b1;
         step();
      end
      check("drain_count", 32'(count), 0);
      check("drain_rd_valid", 32'(rd_valid), 0);
      step();
      rd_ready = 1'b0;
      check("empty_ready_count", 32'(count), 0);
      check("overflow_sticky", 32'(overflow), 1);

      // Flush with count=5 and wrong-path write/read in the same cycle
      for (int i = 0; i < 5; i++) push_word(16 + i);
      check("pre_flush_count", 32'(count), 5);
      flush    = 1'b1;
      rd_ready = 1'b1;
      wr_valid = 1'b1;
      wr_pc    = 11'h3FF;
      wr_instr = 32'hDEAD_BEEF;
      step();
      idle();
      check("flush_count", 32'(count), 0);
      check("flush_rd_valid", 32'(rd_valid), 0);
      check("flush_fifo_full", 32'(fifo_full), 0);
      check("flush_keeps_overflow", 32'(overflow), 1);
      push_word(32'h200);
      check("post_flush_rd_valid", 32'(rd_valid), 1);
      check("post_flush_rd_pc", 32'(rd_pc), 32'h200);
      check("post_flush_count", 32'(count), 1);

      // Reset clears overflow and discards contents
      reset = 1'b1;
      step();
      idle();
      check("rst2_overflow", 32'(overflow), 0);
      check("rst2_count", 32'(count), 0);

      // Stream 20 words, writer throttled by fifo_full, reader toggling
      rd_seen = 0;
      wr_idx  = 0;
      cyc     = 0;
      while (rd_seen < 20 && cyc < 200) begin
         rd_ready = cyc[0];
         if (rd_valid && rd_ready) begin
            check($sformatf("stream_pc_%0d", rd_seen), 32'(rd_pc), 32'(rd_seen));
            check($sformatf("stream_instr_%0d", rd_seen), rd_instr, instr_of(rd_seen));
            rd_seen++;
         end
         if (wr_idx < 20 && !fifo_full) begin
            wr_valid = 1'b1;
            wr_pc    = PC_W'(wr_idx);
            wr_instr = instr_of(wr_idx);
            wr_idx++;
         end else begin
            wr_valid = 1'b0;
         end
         step();
         cyc++;
      end
      idle();
      check("stream_reads", 32'(rd_seen), 20);
      check("stream_overflow", 32'(overflow), 0);
      check("stream_count", 32'(count), 0);

      // Reset mid-stream with three entries
      for (int i = 0; i < 3; i++) push_word(40 + i);
      check("pre_rst_count", 32'(count), 3);
      reset    = 1'b1;
      flush    = 1'b1;
      wr_valid = 1'b1;
      step();
      idle();
      check("rst3_count", 32'(count), 0);
      check("rst3_rd_valid", 32'(rd_valid), 0);
      check("rst3_overflow", 32'(overflow), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_fetch_queue
